dm_job_scheduler: RTL and testbench
===================================

// Module: dm_job_scheduler
// PURPOSE
//  Shares one data_mover core between NREQ requesters. Each requester submits a copy
//  descriptor (src, dst, length) over valid/ready. Round-robin arbitration grants one
//  job at a time; the block drives the mover's config and start pulse, waits for idle,
//  then signals per-requester completion. Sits between control logic and data_mover.
// PARAMETERS
//  NREQ   2      number of requesters (2..8)
//  AW     64     address width, matches data_mover AW
//  DW     512    data_mover data width; alignment unit ALIGN = DW/8 bytes
//  LW     32     descriptor length width; zero-extended to 64 for dm_byte_count
//  BURST  4096   value driven on dm_burst_size, constant
//  TMO    16     cycles allowed for dm_idle to fall after dm_start
// PORTS
//  clk            in   1         clock
//  resetn         in   1         asynchronous active-low reset
//  req_valid      in   NREQ      descriptor valid, one bit per requester
//  req_ready      out  NREQ      descriptor accepted (one-hot or zero)
//  req_src        in   NREQ*AW   source addresses, requester i at [i*AW +: AW]
//  req_dst        in   NREQ*AW   destination addresses
//  req_len        in   NREQ*LW   byte counts
//  done           out  NREQ      one-cycle completion pulse to the owning requester
//  done_err       out  1         qualifies done: 1 = job rejected or timed out
//  busy           out  1         high from grant until done pulse
//  jobs_done      out  32        count of successful jobs, wraps 2^32-1 -> 0
//  dm_src_address out  AW        to data_mover src_address
//  dm_dst_address out  AW        to data_mover dst_address
//  dm_byte_count  out  64        to data_mover byte_count
//  dm_burst_size  out  32        to data_mover burst_size, tied to BURST
//  dm_start       out  1         one-cycle start pulse to data_mover
//  dm_idle        in   1         data_mover idle
// BEHAVIOUR
//  Reset: all outputs 0 except dm_burst_size=BURST; state IDLE; rr pointer = 0.
//  The same resetn drives data_mover, so no drain is needed. Reset mid-job abandons
//  the job with no done pulse.
//  FSM:
//   IDLE  If any req_valid and dm_idle, grant the first valid at or after the rr pointer
//         (wrapping). Assert req_ready[g] combinationally in that cycle and latch the
//         descriptor; rr pointer <= g+1 mod NREQ; go to CHECK. If dm_idle=0, grant nothing.
//   CHECK Reject if len==0, or src, dst or len not a multiple of ALIGN. On reject, go to
//         DONE with err=1. Otherwise drive dm_* registers and go to START.
//   START dm_start=1 for exactly one cycle (dm_* config stable from CHECK onward); go to
//         WAIT_BUSY.
//   WAIT_BUSY Wait for dm_idle=0, then go to WAIT_DONE. If TMO cycles pass without it,
//         go to DONE with err=1.
//   WAIT_DONE Wait for dm_idle=1, then go to DONE with err=0. No timeout.
//   DONE  done[g]=1 and done_err=err for one cycle; jobs_done+1 if !err; back to IDLE.
//  Latency: grant to dm_start = 2 cycles. Mover idle to done = 1 cycle.
//  Minimum gap between jobs: 1 IDLE cycle.
//  dm_* config holds its last value after a job; changes only in CHECK.
//  busy = (state != IDLE). req_ready is 0 in every state except IDLE.
//  A requester that drops req_valid before it is granted loses nothing; arbitration is
//  re-evaluated each IDLE cycle.
//  Simultaneous requests: strict round-robin, so no requester waits more than NREQ-1
//  jobs.
//  A requester re-asserting req_valid in the same cycle as its done pulse is legal; it
//  is considered in the next IDLE cycle.
// STRUCTURE
//  Package dm_sched_pkg: state enum (IDLE, CHECK, START, WAIT_BUSY, WAIT_DONE, DONE)
//  and the ALIGN-check localparam/function.
//  Sub-module rr_arbiter (NREQ): inputs req vector, pointer, enable; outputs one-hot
//  grant and its index. Pure combinational; the pointer register lives in the parent.
// TESTING
//  1. Single job: req0 src=0 dst=0 len=0x10_0000 -> dm_start 2 cycles after ready;
//     dm_byte_count=0x10_0000, dm_burst_size=4096; done[0] after mover idle;
//     jobs_done=1.
//  2. Both valid every cycle, 6 jobs -> grant order 0,1,0,1,0,1; done pulses match
//     owners; no overlapping busy.
//  3. len=0, then src=0x20 (unaligned), each submitted -> no dm_start; done with
//     done_err=1; jobs_done unchanged.
//  4. Mover model never drops idle -> done_err=1 after exactly 16 cycles in WAIT_BUSY;
//     next request serviced normally.
//  5. resetn low during WAIT_DONE -> all outputs 0 asynchronously; no done pulse;
//     after release a new job runs normally from rr pointer 0.
//  6. jobs_done preset near 0xFFFF_FFFF via forced jobs -> wraps to 0 on the next
//     successful completion.

Source files
------------

// File: rtl/dm_sched_pkg.sv
// rtl/dm_sched_pkg.sv - shared types and alignment helper for the data_mover job scheduler
package dm_sched_pkg;

  // Scheduler FSM states, one job in flight at a time
  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_e;

  // Width the alignment check operates on; addresses and lengths are zero-extended to it
  localparam int unsigned CHECK_W = 64;

  // True when value is a whole multiple of align_bytes (align_bytes must be a power of two)
  function automatic logic is_aligned(input logic [CHECK_W-1:0] value, input int align_bytes);
    logic [CHECK_W-1:0] mask;
    mask = CHECK_W'(align_bytes) - CHECK_W'(1);
    return (value & mask) == '0;
  endfunction

endpackage

// File: rtl/dm_job_scheduler_rr_arbiter.sv
// rtl/dm_job_scheduler_rr_arbiter.sv - combinational round-robin picker starting at a pointer
module rr_arbiter
  import dm_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk the requesters from ptr upward with wrap, taking the first one that is asserted
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      idx = sum[IW-1:0];
      if (en && !gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_job_scheduler.sv
// rtl/dm_job_scheduler.sv - round-robin job scheduler sharing one data_mover core
module dm_job_scheduler
  import dm_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int AW    = 64,
  parameter int DW    = 512,
  parameter int LW    = 32,
  parameter int BURST = 4096,
  parameter int TMO   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_src,
  input  logic [NREQ*AW-1:0] req_dst,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]   done,
  output logic              done_err,
  output logic              busy,
  output logic [31:0]       jobs_done,
  output logic [AW-1:0]     dm_src_address,
  output logic [AW-1:0]     dm_dst_address,
  output logic [63:0]       dm_byte_count,
  output logic [31:0]       dm_burst_size,
  output logic              dm_start,
  input  logic              dm_idle
);

  localparam int ALIGN = DW / 8;
  localparam int IW    = $clog2(NREQ);
  localparam int TW    = $clog2(TMO + 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [AW-1:0]  src_q, src_d;
  logic [AW-1:0]  dst_q, dst_d;
  logic [LW-1:0]  len_q, len_d;
  logic           err_q, err_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [31:0]    jobs_q, jobs_d;
  logic [AW-1:0]  dm_src_q, dm_src_d;
  logic [AW-1:0]  dm_dst_q, dm_dst_d;
  logic [63:0]    dm_cnt_q, dm_cnt_d;

  logic           arb_en;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           arb_valid;
  logic [AW-1:0]  sel_src;
  logic [AW-1:0]  sel_dst;
  logic [LW-1:0]  sel_len;
  logic           desc_ok;

  // Only arbitrate while idle, out of reset, and with the mover ready for a new job
  assign arb_en = resetn && (state_q == IDLE) && dm_idle;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .en        (arb_en),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Route the granted requester's descriptor to the capture registers
  always_comb begin
    sel_src = '0;
    sel_dst = '0;
    sel_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_src = req_src[i*AW +: AW];
        sel_dst = req_dst[i*AW +: AW];
        sel_len = req_len[i*LW +: LW];
      end
    end
  end

  // A descriptor is runnable only if it moves something and every field is mover-aligned
  assign desc_ok = (len_q != '0)
                && is_aligned(CHECK_W'(src_q), ALIGN)
                && is_aligned(CHECK_W'(dst_q), ALIGN)
                && is_aligned(CHECK_W'(len_q), ALIGN);

  // Next-state logic: accept, validate, launch, watch the mover, report
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    jobs_d   = jobs_q;
    dm_src_d = dm_src_q;
    dm_dst_d = dm_dst_q;
    dm_cnt_d = dm_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d  = arb_idx;
          src_d    = sel_src;
          dst_d    = sel_dst;
          len_d    = sel_len;
          rr_ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (!desc_ok) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          err_d    = 1'b0;
          dm_src_d = src_q;
          dm_dst_d = dst_q;
          dm_cnt_d = 64'(len_q);
          state_d  = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!dm_idle) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (dm_idle) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!err_q) begin
          jobs_d = jobs_q + 32'd1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any job in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      jobs_q   <= '0;
      dm_src_q <= '0;
      dm_dst_q <= '0;
      dm_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      jobs_q   <= jobs_d;
      dm_src_q <= dm_src_d;
      dm_dst_q <= dm_dst_d;
      dm_cnt_q <= dm_cnt_d;
    end
  end

  // Completion strobe goes only to the requester that owns the finishing job
  always_comb begin
    done = '0;
    for (int i = 0; i < NREQ; i++) begin
      done[i] = (state_q == DONE) && (owner_q == IW'(i));
    end
  end

  assign req_ready      = arb_gnt;
  assign done_err       = (state_q == DONE) && err_q;
  assign busy           = (state_q != IDLE);
  assign dm_start       = (state_q == START);
  assign jobs_done      = jobs_q;
  assign dm_src_address = dm_src_q;
  assign dm_dst_address = dm_dst_q;
  assign dm_byte_count  = dm_cnt_q;
  assign dm_burst_size  = 32'(BURST);

endmodule

// File: tb/tb_dm_job_scheduler.sv
// tb/tb_dm_job_scheduler.sv - scoreboard bench for dm_job_scheduler
module tb_dm_job_scheduler;
  localparam int NREQ  = 2;
  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int LW    = 32;
  localparam int BURST = 4096;
  localparam int TMO   = 16;

  logic               clk = 1'b0;
  logic               resetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_src;
  logic [NREQ*AW-1:0] req_dst;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ-1:0]    done;
  logic               done_err;
  logic               busy;
  logic [31:0]        jobs_done;
  logic [AW-1:0]      dm_src_address;
  logic [AW-1:0]      dm_dst_address;
  logic [63:0]        dm_byte_count;
  logic [31:0]        dm_burst_size;
  logic               dm_start;
  logic               dm_idle;

  dm_job_scheduler #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW), .BURST(BURST), .TMO(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
    .done(done), .done_err(done_err), .busy(busy), .jobs_done(jobs_done),
    .dm_src_address(dm_src_address), .dm_dst_address(dm_dst_address),
    .dm_byte_count(dm_byte_count), .dm_burst_size(dm_burst_size),
    .dm_start(dm_start), .dm_idle(dm_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    bit          rej;
    bit          err;
    logic [63:0] src;
    logic [63:0] dst;
    logic [31:0] len;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          m_ptr = 0;
  logic [31:0] exp_jobs = 32'd0;
  bit          stuck = 1'b0;
  int          busy_len = 4;
  int          mv_cnt = 0;
  int          idle_rise_cyc = 0;
  int          start_cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // data_mover stand-in: goes busy on dm_start for busy_len cycles unless stuck
  initial begin
    dm_idle = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (resetn !== 1'b1) begin
        dm_idle = 1'b1;
        mv_cnt  = 0;
      end else begin
        if (mv_cnt > 0) begin
          mv_cnt--;
          if (mv_cnt == 0) begin
            dm_idle = 1'b1;
            idle_rise_cyc = cyc;
          end
        end
        if (dm_start === 1'b1 && !stuck) begin
          dm_idle = 1'b0;
          mv_cnt  = busy_len;
        end
      end
    end
  end

  // Scoreboard: predict grants, push expectations, check mover config and completions
  initial begin
    int g;
    int idx;
    logic [NREQ-1:0] exp_oh;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (resetn !== 1'b1) begin
        sb.delete();
        m_ptr = 0;
        exp_jobs = 32'd0;
      end else begin
        if (req_ready !== '0) begin
          g = -1;
          for (int i = 0; i < NREQ; i++) begin
            idx = (m_ptr + i) % NREQ;
            if (g < 0 && req_valid[idx] === 1'b1) g = idx;
          end
          exp_oh = (g >= 0 && dm_idle === 1'b1) ? (NREQ'(1) << g) : '0;
          checks++;
          if (req_ready !== exp_oh)
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_oh);
          if (req_ready !== exp_oh) errors++;
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_grant: busy=%b expected 0", busy);
          end
          if (exp_oh != '0) begin
            e.owner = g;
            e.src   = req_src[g*AW +: AW];
            e.dst   = req_dst[g*AW +: AW];
            e.len   = req_len[g*LW +: LW];
            e.rej   = (e.len == 32'd0) || (e.src[5:0] != 6'd0) ||
                      (e.dst[5:0] != 6'd0) || (e.len[5:0] != 6'd0);
            e.err   = e.rej || stuck;
            sb.push_back(e);
            grant_log.push_back(g);
            m_ptr = (g + 1) % NREQ;
          end
        end
        if (dm_start === 1'b1) begin
          start_cyc = cyc;
          checks++;
          if (sb.size() == 0 || sb[0].rej) begin
            errors++;
            $display("FAIL unexpected_start: dm_start=1 expected no start");
          end else if ({dm_src_address, dm_dst_address, dm_byte_count, dm_burst_size} !==
                       {sb[0].src, sb[0].dst, 64'(sb[0].len), 32'(BURST)}) begin
            errors++;
            $display("FAIL dm_config: src=%h dst=%h cnt=%h burst=%0d expected src=%h dst=%h cnt=%h burst=%0d",
                     dm_src_address, dm_dst_address, dm_byte_count, dm_burst_size,
                     sb[0].src, sb[0].dst, 64'(sb[0].len), BURST);
          end
        end
        if (done !== '0) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL spurious_done: done=%b expected no pulse", done);
          end else begin
            e = sb.pop_front();
            if (done !== (NREQ'(1) << e.owner) || done_err !== e.err) begin
              errors++;
              $display("FAIL done_owner: done=%b err=%b expected done=%b err=%b",
                       done, done_err, NREQ'(1) << e.owner, e.err);
            end
            if (!e.err) exp_jobs = exp_jobs + 32'd1;
          end
        end
      end
    end
  end

  task automatic set_desc(input int i, input logic [63:0] s, input logic [63:0] d, input logic [31:0] l);
    req_src[i*AW +: AW] = s;
    req_dst[i*AW +: AW] = d;
    req_len[i*LW +: LW] = l;
  endtask

  task automatic submit(input int i, output bit ok, output int gcyc);
    ok = 1'b0;
    gcyc = 0;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (req_ready[i] === 1'b1) begin
        ok = 1'b1;
        gcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    grant_log.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, done, done_err, busy, dm_start} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b done=%b err=%b busy=%b start=%b expected all 0",
               req_ready, done, done_err, busy, dm_start);
    end
    checks++;
    if ({jobs_done, dm_src_address, dm_dst_address, dm_byte_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: jobs=%h src=%h dst=%h cnt=%h expected 0",
               jobs_done, dm_src_address, dm_dst_address, dm_byte_count);
    end
    checks++;
    if (dm_burst_size !== 32'd4096) begin
      errors++;
      $display("FAIL reset_burst: burst=%0d expected 4096", dm_burst_size);
    end
    req_valid = '0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single_job();
    bit ok;
    int gcyc;
    busy_len = 4;
    set_desc(0, 64'h0, 64'h0, 32'h0010_0000);
    submit(0, ok, gcyc);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_grant: no req_ready expected grant"); end
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (dm_start === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || cyc !== gcyc + 2) begin
      errors++;
      $display("FAIL start_latency: start_seen=%0d cycles=%0d expected 2", ok, cyc - gcyc);
    end
    wait_done(60, ok);
    checks++;
    if (!ok || done !== 2'b01 || cyc !== idle_rise_cyc + 1) begin
      errors++;
      $display("FAIL single_done: done=%b lat=%0d expected done=01 lat=1", done, cyc - idle_rise_cyc);
    end
    @(negedge clk);
    checks++;
    if (jobs_done !== 32'd1) begin
      errors++;
      $display("FAIL single_jobs: jobs_done=%0d expected 1", jobs_done);
    end
  endtask

  task automatic test_round_robin();
    int ndone;
    int exp_order[6];
    exp_order = '{0, 1, 0, 1, 0, 1};
    do_reset();
    busy_len = 3;
    set_desc(0, 64'h1000, 64'h2000, 32'h80);
    set_desc(1, 64'h40, 64'h8000, 32'h1000);
    req_valid = 2'b11;
    ndone = 0;
    for (int n = 0; n < 200 && ndone < 6; n++) begin
      @(negedge clk);
      if (done !== '0) ndone++;
    end
    req_valid = '0;
    checks++;
    if (ndone != 6 || grant_log.size() != 6) begin
      errors++;
      $display("FAIL rr_count: done=%0d grants=%0d expected 6", ndone, grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] != exp_order[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: granted %0d expected %0d", i, grant_log[i], exp_order[i]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (jobs_done !== exp_jobs) begin
      errors++;
      $display("FAIL rr_jobs: jobs_done=%0d expected %0d", jobs_done, exp_jobs);
    end
  endtask

  task automatic test_reject();
    bit ok;
    int gcyc;
    logic [31:0] j0;
    j0 = exp_jobs;
    set_desc(0, 64'h0, 64'h0, 32'h0);
    submit(0, ok, gcyc);
    wait_done(20, ok);
    checks++;
    if (!ok || done_err !== 1'b1) begin
      errors++;
      $display("FAIL reject_len0: done_seen=%0d err=%b expected err=1", ok, done_err);
    end
    set_desc(1, 64'h20, 64'h0, 32'h40);
    submit(1, ok, gcyc);
    wait_done(20, ok);
    checks++;
    if (!ok || done_err !== 1'b1) begin
      errors++;
      $display("FAIL reject_unaligned: done_seen=%0d err=%b expected err=1", ok, done_err);
    end
    @(negedge clk);
    checks++;
    if (jobs_done !== j0) begin
      errors++;
      $display("FAIL reject_jobs: jobs_done=%0d expected %0d", jobs_done, j0);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int gcyc;
    stuck = 1'b1;
    set_desc(0, 64'h40, 64'h80, 32'h40);
    submit(0, ok, gcyc);
    wait_done(60, ok);
    checks++;
    if (!ok || done_err !== 1'b1 || cyc !== start_cyc + TMO + 1) begin
      errors++;
      $display("FAIL timeout: done_seen=%0d err=%b cycles=%0d expected err=1 cycles=%0d",
               ok, done_err, cyc - start_cyc, TMO + 1);
    end
    stuck = 1'b0;
    @(negedge clk);
    set_desc(1, 64'h100, 64'h200, 32'h400);
    submit(1, ok, gcyc);
    wait_done(60, ok);
    checks++;
    if (!ok || done_err !== 1'b0 || done !== 2'b10) begin
      errors++;
      $display("FAIL after_timeout: done=%b err=%b expected done=10 err=0", done, done_err);
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    int gcyc;
    busy_len = 20;
    set_desc(1, 64'h4000, 64'h8000, 32'h200);
    submit(1, ok, gcyc);
    for (int n = 0; n < 20 && dm_idle !== 1'b0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({req_ready, done, done_err, busy, dm_start, jobs_done, dm_src_address,
         dm_dst_address, dm_byte_count} !== '0 || dm_burst_size !== 32'd4096) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b start=%b jobs=%h src=%h cnt=%h burst=%0d expected 0/4096",
               busy, done, dm_start, jobs_done, dm_src_address, dm_byte_count, dm_burst_size);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (done !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: done=%b busy=%b expected 0", done, busy);
      end
    end
    resetn = 1'b1;
    busy_len = 4;
    set_desc(0, 64'h0, 64'h40, 32'h40);
    set_desc(1, 64'h0, 64'h40, 32'h40);
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_ptr: req_ready=%b expected 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_done(60, ok);
    checks++;
    if (!ok || done !== 2'b01 || done_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_job: done=%b err=%b expected 01/0", done, done_err);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int gcyc;
    @(negedge clk);
    force dut.jobs_q = 32'hFFFF_FFFE;
    exp_jobs = 32'hFFFF_FFFE;
    #1;
    release dut.jobs_q;
    @(negedge clk);
    busy_len = 2;
    for (int k = 0; k < 2; k++) begin
      set_desc(k, 64'h40 * (k + 1), 64'h1000, 32'h40);
      submit(k, ok, gcyc);
      wait_done(60, ok);
      @(negedge clk);
      checks++;
      if (!ok || jobs_done !== (k == 0 ? 32'hFFFF_FFFF : 32'h0)) begin
        errors++;
        $display("FAIL wrap[%0d]: jobs_done=%h expected %h", k, jobs_done,
                 (k == 0 ? 32'hFFFF_FFFF : 32'h0));
      end
    end
  endtask

  initial begin
    req_valid = '0;
    req_src = '0;
    req_dst = '0;
    req_len = '0;
    test_reset();
    test_single_job();
    test_round_robin();
    test_reject();
    test_timeout();
    test_reset_mid_job();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
